reg_fifo_buf: RTL

//  Parametrised register-based FIFO with val/rdy handshakes on both sides.

---
 rtl/music_pkg.sv | 16 +
 rtl/reg_fifo_buf_if.sv | 31 +++
 rtl/register_nb_en.sv | 22 ++
 rtl/reg_fifo_buf.sv | 78 +++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared constants and helpers for the music-player datapath blocks.
package music_pkg;

  // Default FIFO geometry between the sequencer and the tone/PWM stage.
  localparam int FIFO_W = 8;
  localparam int FIFO_D = 4;

  // Width needed to hold a count in the range 0..d inclusive.
  function automatic int fifo_cw(input int d);
    return $clog2(d + 1);
  endfunction

  // Occupancy count type for the default-depth FIFO.
  typedef logic [fifo_cw(FIFO_D)-1:0] fifo_count_t;

endpackage

// File: rtl/reg_fifo_buf_if.sv
// Producer/consumer handshake bundle for reg_fifo_buf.
interface reg_fifo_buf_if
  import music_pkg::*;
#(
  parameter int W = FIFO_W,
  parameter int D = FIFO_D
);

  localparam int CW = fifo_cw(D);

  logic          in_val;
  logic          in_rdy;
  logic [W-1:0]  in_data;
  logic          out_val;
  logic          out_rdy;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  // Sequencer and tone stage side: drives requests, observes FIFO state.
  modport master (
    output in_val, in_data, out_rdy,
    input  in_rdy, out_val, out_data, count
  );

  // FIFO side.
  modport slave (
    input  in_val, in_data, out_rdy,
    output in_rdy, out_val, out_data, count
  );

endinterface

// File: rtl/register_nb_en.sv
// W-bit register with load enable and asynchronous active-low clear.
module register_nb_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable; hold otherwise.
  // NOTE: storage is reset too, so out_data is a defined 0 straight after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_fifo_buf.sv
// Register-based FIFO, W bits x D entries, val/rdy on both sides.
// Async active-low reset, synchronous flush (clr) with priority over
// push/pop. Head word is read combinationally; no empty bypass.
module reg_fifo_buf
  import music_pkg::*;
#(
  parameter int W = FIFO_W,
  parameter int D = FIFO_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  reg_fifo_buf_if.slave bus
);

  localparam int CW = fifo_cw(D);
  localparam int PW = $clog2(D);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  entry [D];
  logic          in_rdy;
  logic          out_val;
  logic          push;
  logic          pop;
  logic          wr_en;

  assign in_rdy = (cnt != CW'(D));
  assign out_val = (cnt != '0);
  assign push = bus.in_val & in_rdy;
  assign pop = out_val & bus.out_rdy;
  // A flushed push is dropped, so the entry is not written either.
  assign wr_en = push & ~clr;

  // One storage register per entry, loaded only when it is the write target.
  for (genvar i = 0; i < D; i++) begin : g_entry
    register_nb_en #(.W(W)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wr_en && (wr_ptr == PW'(i))),
      .d   (bus.in_data),
      .q   (entry[i])
    );
  end

  // Pointers and occupancy: explicit compare-and-wrap so any depth works.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_val  = out_val;
  assign bus.out_data = out_val ? entry[rd_ptr] : '0;
  assign bus.count    = cnt;

endmodule
